// File: rtl/rr_rec_merger.sv
// Record-FIFO merger: keeps the channel FIFOs in lock-step with bubble pushes, pops one
// entry group from all of them at once, and emits it as a header beat plus one beat per real packet.
module rr_rec_merger #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       new_packet,
  output logic [NCH-1:0]       bubble_en,
  input  logic [NCH-1:0]       rec_valid,
  output logic [NCH-1:0]       rec_ready,
  input  logic [NCH-1:0]       rec_ispkt,
  input  logic [NCH-1:0]       rec_busy,
  input  logic [NCH*WIDTH-1:0] rec_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [31:0]          group_cnt,
  output logic                 err_desync
);

  // state | meaning
  // IDLE  | waiting for every channel FIFO to be valid; pops the group in that cycle
  // HDR   | emitting the header beat {bmask, pmask}
  // PAY   | emitting the payload of channel ptr
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           state, state_nxt;
  logic [NCH-1:0]   pmask, bmask, above;
  logic [WIDTH-1:0] payload [NCH];
  logic [PW-1:0]    ptr;
  logic             pop, fire;

  function automatic logic [PW-1:0] lowest(input logic [NCH-1:0] m);
    lowest = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) lowest = PW'(i);
  endfunction

  assign bubble_en = {NCH{|new_packet}} & ~new_packet;

  // Packets still to be sent after the current one.
  always_comb begin
    above = '0;
    for (int i = 0; i < NCH; i++)
      if (i > int'(ptr)) above[i] = pmask[i];
  end

  always_comb begin
    state_nxt = state;
    rec_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (&rec_valid) begin
          rec_ready = '1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        out_valid = 1'b1;
        out_data  = OUT_WIDTH'({bmask, pmask});
        out_last  = (pmask == '0);
        if (out_ready) state_nxt = (pmask == '0) ? IDLE : PAY;
      end
      PAY: begin
        out_valid = 1'b1;
        out_data  = OUT_WIDTH'(payload[ptr]);
        out_last  = (above == '0);
        if (out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop  = (state == IDLE) && (&rec_valid);
  assign fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pmask      <= '0;
      bmask      <= '0;
      ptr        <= '0;
      group_cnt  <= '0;
      err_desync <= 1'b0;
      for (int i = 0; i < NCH; i++) payload[i] <= '0;
    end else begin
      state <= state_nxt;
      if ((|rec_valid) && !(&rec_valid)) err_desync <= 1'b1;
      if (pop) begin
        pmask <= rec_ispkt;
        bmask <= rec_busy;
        for (int i = 0; i < NCH; i++) payload[i] <= rec_data[i*WIDTH +: WIDTH];
      end
      if (fire && state == HDR) begin
        if (pmask == '0) group_cnt <= group_cnt + 32'd1;
        else             ptr       <= lowest(pmask);
      end
      if (fire && state == PAY) begin
        pmask[ptr] <= 1'b0;
        if (above == '0) group_cnt <= group_cnt + 32'd1;
        else             ptr       <= lowest(above);
      end
    end
  end

endmodule
